// File: rtl/spram_be.sv
// Single-port synchronous RAM with per-byte write enables, optional write-through,
// optional output register and a clear engine that fills the array with INIT_VAL
// after reset or on request.
module spram_be #(
  parameter int unsigned   WD       = 32,
  parameter int unsigned   DP       = 16,
  parameter int unsigned   AD       = $clog2(DP),
  parameter int unsigned   BW       = WD / 8,
  parameter int unsigned   OUT_REG  = 0,
  parameter int unsigned   RDW_MODE = 0,
  parameter logic [WD-1:0] INIT_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          cs_ni,
  input  logic          w_r_ni,
  input  logic [BW-1:0] be_i,
  input  logic [AD-1:0] addr_i,
  input  logic [WD-1:0] din_i,
  output logic [WD-1:0] dout_o,
  output logic          dout_vld_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e        state_q;
  logic [AD-1:0] cnt_q;
  logic          busy_q;
  logic          err_q;
  logic [WD-1:0] dout_q;
  logic          dout_vld_q;
  logic [WD-1:0] s1_data_q;
  logic          s1_vld_q;

  logic [WD-1:0] mem_q [DP];

  logic          in_range;
  logic          rd_fire;
  logic          wr_fire;
  logic [WD-1:0] mem_rdata;
  logic [WD-1:0] merged;
  logic          res_vld;
  logic [WD-1:0] res_data;
  logic          out_vld;
  logic [WD-1:0] out_data;
  logic          mem_we;
  logic [AD-1:0] mem_waddr;
  logic [WD-1:0] mem_wdata;

  // Only a non-power-of-two depth leaves unbacked addresses.
  if ((1 << AD) == DP) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (addr_i < AD'(DP));
  end

  // Access decode, byte merge and clear/write port arbitration.
  always_comb begin
    rd_fire   = (state_q == StReady) && !clr_i && !cs_ni && !w_r_ni;
    wr_fire   = (state_q == StReady) && !clr_i && !cs_ni && w_r_ni;
    mem_rdata = in_range ? mem_q[addr_i] : '0;
    merged    = mem_rdata;
    for (int i = 0; i < int'(BW); i++) begin
      if (be_i[i]) merged[8*i +: 8] = din_i[8*i +: 8];
    end
    res_vld  = rd_fire || (wr_fire && (RDW_MODE != 0));
    res_data = in_range ? (w_r_ni ? merged : mem_rdata) : '0;

    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = merged;
    if (state_q == StClear && !clr_i) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VAL;
    end else if (wr_fire && in_range && (|be_i)) begin
      mem_we = 1'b1;
    end

    // With OUT_REG the result passes through one extra stage before dout.
    out_vld  = (OUT_REG != 0) ? s1_vld_q  : res_vld;
    out_data = (OUT_REG != 0) ? s1_data_q : res_data;
  end

  // Storage array; deliberately not reset, the clear engine initialises it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Clear/ready FSM with registered busy, err and output pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      s1_data_q  <= '0;
      s1_vld_q   <= 1'b0;
    end else begin
      // Any access that arrives while clearing, or alongside a clear request, is refused.
      err_q <= !cs_ni && ((state_q == StClear) || clr_i);
      if (clr_i) begin
        state_q <= StClear;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (state_q == StClear) begin
        if (cnt_q == AD'(DP - 1)) begin
          state_q <= StReady;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + AD'(1);
        end
      end
      // The pipeline is left alone by clr so an in-flight read still completes.
      if (res_vld) s1_data_q <= res_data;
      s1_vld_q <= res_vld;
      if (out_vld) dout_q <= out_data;
      dout_vld_q <= out_vld;
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = dout_vld_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: doc/spram_be.md
# spram_be

Parameterised single-port synchronous RAM with per-byte write enables, a selectable write-through mode, an optional output register and a hardware clear engine. After reset, or on a `clr` request, the clear engine writes `INIT_VAL` to every location. It is the general-purpose scratch/buffer memory for datapath blocks that need byte-granular updates and known contents at start-up. Access protocol keeps the active-low `cs_n` / `w_r_n` style: `w_r_n`=1 write, 0 read.

## Interface
- `WD`, 32: data width in bits; must be a multiple of 8.
- `DP`, 16: depth in words; must be ≥2.
- `AD`, clogb2(`DP`): address width.
- `BW`, `WD`/8: number of byte lanes.
- `OUT_REG`, 0: 0 = read data one cycle after the access; 1 = one extra output pipeline stage.
- `RDW_MODE`, 0: 0 = no-change, `dout` holds during writes; 1 = write-through, the write returns the merged stored word.
- `INIT_VAL`, 0: value the clear engine writes, width `WD`.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous clear request, sampled every edge.
- `cs_n` in 1: chip select, active low.
- `w_r_n` in 1: 1 = write, 0 = read.
- `be` in `BW`: byte enables, active high; `be[i]` covers `din[8i+7:8i]`.
- `addr` in `AD`: word address.
- `din` in `WD`: write data.
- `dout` out `WD`: read data, registered.
- `dout_vld` out 1: one-cycle pulse marking new `dout`.
- `busy` out 1: clear engine running; accesses are refused.
- `err` out 1: one-cycle pulse when an access is refused.

## Operation
- **FSM states.** CLEAR and READY.
- **Reset.** `rst_n`=0 forces:
  - state CLEAR, clear counter 0;
  - `busy`=1, `dout`=0, `dout_vld`=0, `err`=0;
  - output pipeline valid flag cleared.
  - Array contents are not reset asynchronously.
- **CLEAR.**
  - Each edge writes `INIT_VAL` to the counter address, all lanes, then increments the counter.
  - On the edge that writes `DP`-1: go to READY, `busy`←0.
  - `cs_n`/`w_r_n` are ignored in CLEAR.
- **READY, `clr`=1.**
  - Next state is CLEAR, counter←0, `busy`←1.
  - Any access in the same cycle is dropped and `err` pulses.
- **`clr`=1 in CLEAR.** Counter restarts at 0.
- **Access in CLEAR** (`cs_n`=0, `clr`=0): dropped; `err`←1 for one cycle; memory and `dout` unchanged.
- **Read** (READY, `cs_n`=0, `w_r_n`=0): `buffer[addr]` goes to `dout` with `dout_vld`.
- **Write** (READY, `cs_n`=0, `w_r_n`=1):
  - Lanes with `be[i]`=1 take `din`; the other lanes keep their old bytes.
  - `be`=0 is a legal no-op write.
  - `RDW_MODE`=1: the merged word (old bytes + new bytes) is presented on `dout` with `dout_vld`, same latency as a read.
  - `RDW_MODE`=0: `dout` holds and `dout_vld`=0.
- **Deselected** (`cs_n`=1): no memory change; `dout` holds its last value (never X); `dout_vld`=0.
- **Address range.** `addr` ≥ `DP` (non-power-of-2 `DP`):
  - writes are discarded;
  - reads return 0 with `dout_vld`=1;
  - no `err`.
- **In-flight reads.** A read already in the `OUT_REG` stage when `clr` is accepted still completes: `dout_vld` pulses with the pre-clear data.

## Timing
- **Clear length.** With `rst_n` released before edge 1, the clear occupies edges 1..`DP`. `busy` falls after edge `DP`; the first honoured access is sampled at edge `DP`+1.
- **A `clr` sampled at edge k:**
  - `busy` is high from after edge k;
  - writes occur at edges k+1..k+`DP`;
  - `busy` is low after edge k+`DP`.
- **Read latency.** Access sampled at edge N:
  - `OUT_REG`=0: `dout`/`dout_vld` valid after edge N.
  - `OUT_REG`=1: valid after edge N+1.
  - Back-to-back accesses give one result per cycle.
- **Read-after-write, same address.**
  - Write at edge N, read at edge N+1: the read returns the new data.
  - Write-through data in `RDW_MODE`=1 has the same latency as a read.
- **`err`.** Asserted the cycle after the refused access, for exactly one cycle per refused access.

## Test plan
- **Reset + clear** (`WD`=32, `DP`=16, `INIT_VAL`=32'hA5A5_A5A5): release `rst_n`, wait for `busy`=0, read addresses 0..15 → every `dout`=32'hA5A5_A5A5. `busy` is high for exactly 16 edges.
- **Byte enables:**
  - Write 32'h1122_3344 to addr 3 with `be`=4'hF.
  - Then write 32'hFFFF_FFFF with `be`=4'b0101.
  - Read addr 3 → 32'h11FF_33FF. A `be`=0 write leaves it unchanged.
- **Latency:**
  - `OUT_REG`=0, reads of addr 0,1,2 on consecutive edges N..N+2 → three `dout_vld` pulses after edges N..N+2, data in order.
  - `OUT_REG`=1 → the same data after edges N+1..N+3.
- **RDW modes:**
  - `RDW_MODE`=1: write 32'hDEAD_BEEF `be`=4'b1100 over 32'h0000_0000 → `dout`=32'hDEAD_0000, `dout_vld`=1.
  - `RDW_MODE`=0: `dout` unchanged, `dout_vld`=0.
- **Access during clear:**
  - Read and write issued while `busy`=1 → `err` pulses once per access, memory unchanged, `dout_vld`=0.
  - `clr` pulsed mid-clear at counter 7 → the clear restarts and `busy` lasts 16 more edges.
- **Async reset mid-operation:**
  - Assert `rst_n`=0 during back-to-back writes → immediately `busy`=1, `dout`=0, `dout_vld`=0.
  - After release, the full clear runs and all words read `INIT_VAL`.
